// File: rtl/hmac_scheduler.sv
// Round-robin front end sharing one PUF + HMAC engine among NREQ requesters.
// Sequences key generation, streams the granted message and returns the MAC or a timeout error.
module hmac_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_grant,
  input  logic [32*NREQ-1:0]   req_word,
  input  logic [NREQ-1:0]      req_wvalid,
  input  logic [NREQ-1:0]      req_wlast,
  output logic [NREQ-1:0]      req_wready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [511:0]         rsp_mac,
  output logic                 rsp_err,
  input  logic                 key_regen,
  input  logic [703:0]         puf_seed,
  output logic                 key_valid,
  output logic                 start_puf,
  output logic                 start_hmac,
  output logic [703:0]         puf_input,
  output logic [31:0]          msg_word,
  output logic                 msg_valid,
  output logic                 msg_last,
  input  logic                 msg_ready,
  input  logic                 done,
  input  logic [511:0]         hmac_value
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PUF_START, S_PUF_WAIT, S_HMAC_START, S_STREAM, S_HMAC_WAIT, S_RESP
  } state_t;

  state_t            state_r, state_s;
  logic [IW-1:0]     ptr_r, win_r, win_s, ptr_nxt_s;
  logic [IW:0]       idx_s;
  logic              found_s;
  logic              regen_r, regen_pend_s, key_valid_r;
  logic [CW-1:0]     cnt_r;
  logic              in_wait_s, tmo_s, accept_s;
  logic [NREQ-1:0]   grant_r, rsp_valid_r;
  logic [511:0]      rsp_mac_r;
  logic              rsp_err_r, start_puf_r, start_hmac_r;
  logic [703:0]      puf_input_r;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign in_wait_s    = (state_r == S_PUF_WAIT) || (state_r == S_STREAM) || (state_r == S_HMAC_WAIT);
  assign tmo_s        = in_wait_s && (cnt_r == CW'(TIMEOUT));
  assign accept_s     = (state_r == S_STREAM) && req_wvalid[win_r] && msg_ready;
  assign regen_pend_s = regen_r || key_regen || (!key_valid_r && (|req_valid));
  assign ptr_nxt_s    = (win_r == IW'(NREQ - 1)) ? '0 : win_r + IW'(1);

  // Round-robin winner: first pending requester at or above ptr, wrapping
  always_comb begin
    win_s   = ptr_r;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, ptr_r} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(NREQ)) begin
        idx_s = idx_s - (IW+1)'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_valid[idx_s[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic; done beats a simultaneous timeout
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (regen_pend_s)    state_s = S_PUF_START;
        else if (|req_valid) state_s = S_HMAC_START;
        else                 state_s = S_IDLE;
      end
      S_PUF_START:  state_s = S_PUF_WAIT;
      S_PUF_WAIT: begin
        if (done || tmo_s) state_s = S_IDLE;
        else               state_s = S_PUF_WAIT;
      end
      S_HMAC_START: state_s = S_STREAM;
      S_STREAM: begin
        if (accept_s && req_wlast[win_r]) state_s = S_HMAC_WAIT;
        else if (tmo_s && !accept_s)      state_s = S_RESP;
        else                              state_s = S_STREAM;
      end
      S_HMAC_WAIT: begin
        if (done || tmo_s) state_s = S_RESP;
        else               state_s = S_HMAC_WAIT;
      end
      S_RESP:       state_s = S_IDLE;
      default:      state_s = S_IDLE;
    endcase
  end

  // Combinational stream path from the granted requester to the engine
  always_comb begin
    msg_word   = 32'h0;
    msg_valid  = 1'b0;
    msg_last   = 1'b0;
    req_wready = '0;
    if (state_r == S_STREAM) begin
      msg_word          = req_word[{win_r, 5'd0} +: 32];
      msg_valid         = req_wvalid[win_r];
      msg_last          = req_wlast[win_r];
      req_wready[win_r] = msg_ready;
    end else begin
      req_wready = '0;
    end
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      ptr_r        <= '0;
      win_r        <= '0;
      regen_r      <= 1'b0;
      key_valid_r  <= 1'b0;
      cnt_r        <= '0;
      grant_r      <= '0;
      rsp_valid_r  <= '0;
      rsp_mac_r    <= 512'h0;
      rsp_err_r    <= 1'b0;
      start_puf_r  <= 1'b0;
      start_hmac_r <= 1'b0;
      puf_input_r  <= 704'h0;
    end else begin
      state_r <= state_s;

      if ((state_s != state_r) || accept_s) cnt_r <= '0;
      else if (in_wait_s && !tmo_s)         cnt_r <= cnt_r + CW'(1);
      else                                  cnt_r <= cnt_r;

      if (state_r == S_IDLE && state_s == S_HMAC_START) win_r <= win_s;
      else                                               win_r <= win_r;

      if (state_r == S_RESP) ptr_r <= ptr_nxt_s;
      else                   ptr_r <= ptr_r;

      // A pending regen absorbs further pulses until PUF_START consumes it
      if (state_r == S_PUF_START) regen_r <= 1'b0;
      else if (key_regen)         regen_r <= 1'b1;
      else                        regen_r <= regen_r;

      if (state_r == S_PUF_WAIT && done)       key_valid_r <= 1'b1;
      else if (state_r == S_PUF_WAIT && tmo_s) key_valid_r <= 1'b0;
      else                                     key_valid_r <= key_valid_r;

      // Seed is captured on entry so puf_input is valid alongside start_puf
      if (state_s == S_PUF_START && state_r != S_PUF_START) puf_input_r <= puf_seed;
      else                                                  puf_input_r <= puf_input_r;

      start_puf_r  <= (state_s == S_PUF_START);
      start_hmac_r <= (state_s == S_HMAC_START);

      if (state_s == S_HMAC_START)                           grant_r <= onehot(win_s);
      else if (state_s == S_STREAM || state_s == S_HMAC_WAIT) grant_r <= grant_r;
      else                                                   grant_r <= '0;

      if (state_s == S_RESP) rsp_valid_r <= onehot(win_r);
      else                   rsp_valid_r <= '0;

      if (state_r == S_HMAC_WAIT && done) begin
        rsp_mac_r <= hmac_value;
        rsp_err_r <= 1'b0;
      end else if (state_s == S_RESP && state_r != S_RESP) begin
        rsp_mac_r <= 512'h0;
        rsp_err_r <= 1'b1;
      end else begin
        rsp_mac_r <= rsp_mac_r;
        rsp_err_r <= rsp_err_r;
      end
    end
  end

  assign req_grant  = grant_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_mac    = rsp_mac_r;
  assign rsp_err    = rsp_err_r;
  assign key_valid  = key_valid_r;
  assign start_puf  = start_puf_r;
  assign start_hmac = start_hmac_r;
  assign puf_input  = puf_input_r;

endmodule

// File: tb/tb_hmac_scheduler.sv
// Randomized bench for hmac_scheduler: behavioural engine stub plus a round-robin and MAC reference.
module tb_hmac_scheduler;
  localparam int NREQ = 4;
  localparam int TMO  = 60;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_grant, req_wvalid, req_wlast, req_wready, rsp_valid;
  logic [32*NREQ-1:0]   req_word;
  logic [511:0]         rsp_mac, hmac_value;
  logic                 rsp_err, key_regen, key_valid, start_puf, start_hmac;
  logic [703:0]         puf_seed, puf_input;
  logic [31:0]          msg_word;
  logic                 msg_valid, msg_last, msg_ready, done;

  hmac_scheduler #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_grant(req_grant),
    .req_word(req_word), .req_wvalid(req_wvalid), .req_wlast(req_wlast),
    .req_wready(req_wready), .rsp_valid(rsp_valid), .rsp_mac(rsp_mac), .rsp_err(rsp_err),
    .key_regen(key_regen), .puf_seed(puf_seed), .key_valid(key_valid),
    .start_puf(start_puf), .start_hmac(start_hmac), .puf_input(puf_input),
    .msg_word(msg_word), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_ready(msg_ready), .done(done), .hmac_value(hmac_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ref_ptr  = 0;
  int puf_cnt  = 0;
  logic [31:0]  msg_q[$];
  logic [511:0] key_exp;
  bit stall_en = 1'b1, dead_puf = 1'b0, dead_mac = 1'b0;

  task automatic check_eq(input string tag, input logic [703:0] got, input logic [703:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Toy keyed MAC standing in for hmac_top: order-sensitive mixing of words into the key
  function automatic logic [511:0] mac_init(input logic [511:0] key);
    return key ^ {16{32'h5a5a5a5a}};
  endfunction
  function automatic logic [511:0] mix(input logic [511:0] acc, input logic [31:0] w);
    return {acc[498:0], acc[511:499]} ^ {16{w}} ^ {480'd0, w ^ 32'h9e3779b9};
  endfunction
  function automatic logic [511:0] ref_mac(input logic [511:0] key);
    logic [511:0] a;
    a = mac_init(key);
    foreach (msg_q[k]) a = mix(a, msg_q[k]);
    return a;
  endfunction
  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction
  function automatic logic [703:0] rand_seed();
    logic [703:0] s;
    for (int k = 0; k < 22; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  // Engine stub: PUF key from puf_input, MAC over the words it accepts, random msg_ready
  logic [511:0] e_key, e_acc;
  int e_words, e_lasts, m_dly, p_dly;
  always @(posedge clk) begin
    if (!reset) begin
      done <= 1'b0; hmac_value <= '0; e_key <= '0; e_acc <= '0;
      e_words <= 0; e_lasts <= 0; m_dly <= 0; p_dly <= 0; msg_ready <= 1'b0;
    end else begin
      msg_ready <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      done <= 1'b0;
      if (start_puf) begin
        e_key <= puf_input[511:0];
        p_dly <= 4;
      end else if (p_dly != 0) begin
        p_dly <= p_dly - 1;
        if (p_dly == 1 && !dead_puf) done <= 1'b1;
      end
      if (start_hmac) begin
        e_acc <= mac_init(e_key); e_words <= 0; e_lasts <= 0; m_dly <= 0;
      end else if (msg_valid && msg_ready) begin
        e_acc <= mix(e_acc, msg_word);
        e_words <= e_words + 1;
        if (msg_last) begin
          e_lasts <= e_lasts + 1;
          m_dly <= 3;
        end
      end else if (m_dly != 0) begin
        m_dly <= m_dly - 1;
        if (m_dly == 1 && !dead_mac) begin
          done <= 1'b1;
          hmac_value <= e_acc;
        end
      end
    end
  end

  // Monitor: one-hot grant/response and PUF start count
  always @(negedge clk) begin
    if (start_puf === 1'b1) puf_cnt <= puf_cnt + 1;
    if (req_grant != '0) check_eq("grant_onehot", 704'($onehot(req_grant)), 704'd1);
    if (rsp_valid != '0) check_eq("rsp_onehot", 704'($onehot(rsp_valid)), 704'd1);
  end

  task automatic wait_any_grant(output int gi);
    int cyc;
    gi = -1;
    cyc = 0;
    while (req_grant == '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < NREQ; k++) if (req_grant[k]) gi = k;
  endtask

  task automatic serve(input int len, input bit exp_err, input bit do_regen, output int gi);
    int expw, cyc, j, waited;
    logic [511:0] exp_mac;
    expw = rr_pick(req_valid, ref_ptr);
    wait_any_grant(gi);
    check_eq("rr_winner", 704'(gi), 704'(expw));
    if (gi < 0) return;
    check_eq("start_hmac", 704'(start_hmac), 704'd1);
    if (len > 0) begin
      msg_q.delete();
      repeat (len) msg_q.push_back($urandom);
    end
    exp_mac = ref_mac(key_exp);
    j = 0;
    cyc = 0;
    while (j < msg_q.size() && cyc < 3000) begin
      req_wvalid[gi] = 1'b1;
      req_word[32*gi +: 32] = msg_q[j];
      req_wlast[gi] = (j == msg_q.size() - 1);
      key_regen = do_regen && (cyc == 3 || cyc == 6);
      #1;
      if (req_wready[gi]) j++;
      @(negedge clk);
      cyc++;
    end
    req_wvalid = '0;
    req_wlast = '0;
    key_regen = 1'b0;
    check_eq("words_accepted", 704'(j), 704'(msg_q.size()));
    waited = 0;
    while (rsp_valid[gi] !== 1'b1 && waited < TMO + 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rsp_valid", 704'(rsp_valid), 704'd1 << gi);
    check_eq("rsp_err", 704'(rsp_err), 704'(exp_err));
    check_eq("rsp_mac", 704'(rsp_mac), exp_err ? 704'd0 : 704'(exp_mac));
    if (exp_err) begin
      check_eq("tmo_latency", 704'(waited >= TMO && waited <= TMO + 3), 704'd1);
    end else begin
      check_eq("engine_words", 704'(e_words), 704'(msg_q.size()));
      check_eq("engine_lasts", 704'(e_lasts), 704'd1);
    end
    ref_ptr = (gi + 1) % NREQ;
  endtask

  initial begin
    int gi, cyc, p0;
    int lens[5] = '{17, 18, 19, 54, 200};
    logic [703:0] seed_v;
    reset = 1'b0; req_valid = '0; req_word = '0; req_wvalid = '0; req_wlast = '0;
    key_regen = 1'b0; puf_seed = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_grant", 704'(req_grant), 704'd0);
    check_eq("rst_rsp_valid", 704'(rsp_valid), 704'd0);
    check_eq("rst_key_valid", 704'(key_valid), 704'd0);
    check_eq("rst_start_puf", 704'(start_puf), 704'd0);
    check_eq("rst_msg_valid", 704'(msg_valid), 704'd0);
    reset = 1'b1;
    @(negedge clk);

    // First request with no key: PUF first, then grant to requester 2
    seed_v = rand_seed();
    puf_seed = seed_v;
    key_exp = seed_v[511:0];
    req_valid = 4'b0100;
    cyc = 0;
    while (start_puf !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    check_eq("first_start_puf", 704'(start_puf), 704'd1);
    check_eq("puf_input", puf_input, seed_v);
    check_eq("key_invalid_before", 704'(key_valid), 704'd0);
    cyc = 0;
    while (key_valid !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
    check_eq("key_valid_after", 704'(key_valid), 704'd1);
    msg_q.delete();
    msg_q.push_back(32'h12345678);
    serve(0, 1'b0, 1'b0, gi);

    // Fairness with every requester held
    req_valid = '1;
    for (int r = 0; r < 5; r++) serve(1, 1'b0, 1'b0, gi);
    req_valid = '0;

    // Random request masks against the round-robin model
    req_valid = 4'($urandom_range(1, 15));
    for (int r = 0; r < 8; r++) begin
      serve($urandom_range(1, 6), 1'b0, 1'b0, gi);
      if (gi >= 0) req_valid[gi] = 1'b0;
      req_valid = req_valid | 4'($urandom_range(0, 15));
      if (req_valid == '0) req_valid = 4'b0001;
    end
    req_valid = '0;

    // Boundary message lengths on requester 1
    req_valid = 4'b0010;
    foreach (lens[k]) serve(lens[k], 1'b0, 1'b0, gi);
    req_valid = '0;

    // Two regen pulses mid-stream: old key finishes, exactly one regeneration follows
    seed_v = rand_seed();
    puf_seed = seed_v;
    req_valid = 4'b0001;
    serve(12, 1'b0, 1'b1, gi);
    req_valid = 4'b0100;
    p0 = puf_cnt;
    key_exp = seed_v[511:0];
    serve(3, 1'b0, 1'b0, gi);
    check_eq("regen_once", 704'(puf_cnt - p0), 704'd1);
    req_valid = '0;

    // Engine never finishes the MAC
    dead_mac = 1'b1;
    req_valid = 4'b1000;
    serve(2, 1'b1, 1'b0, gi);
    req_valid = '0;
    dead_mac = 1'b0;

    // Engine never finishes key generation, next request re-triggers PUF
    dead_puf = 1'b1;
    seed_v = rand_seed();
    puf_seed = seed_v;
    p0 = puf_cnt;
    key_regen = 1'b1;
    @(negedge clk);
    key_regen = 1'b0;
    cyc = 0;
    while (key_valid !== 1'b0 && cyc < TMO + 30) begin @(negedge clk); cyc++; end
    check_eq("puf_tmo_key_valid", 704'(key_valid), 704'd0);
    check_eq("puf_tmo_starts", 704'(puf_cnt - p0), 704'd1);
    dead_puf = 1'b0;
    key_exp = seed_v[511:0];
    p0 = puf_cnt;
    req_valid = 4'b0001;
    serve(4, 1'b0, 1'b0, gi);
    check_eq("puf_retrigger", 704'(puf_cnt - p0), 704'd1);
    req_valid = '0;

    // One-cycle reset during STREAM, then a fresh request
    req_valid = 4'b0010;
    wait_any_grant(gi);
    check_eq("pre_rst_grant", 704'(gi), 704'(rr_pick(4'b0010, ref_ptr)));
    if (gi >= 0) begin
      repeat (4) begin
        req_wvalid[gi] = 1'b1;
        req_word[32*gi +: 32] = $urandom;
        @(negedge clk);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_grant", 704'(req_grant), 704'd0);
    check_eq("mid_rst_wready", 704'(req_wready), 704'd0);
    check_eq("mid_rst_rsp_valid", 704'(rsp_valid), 704'd0);
    check_eq("mid_rst_rsp_mac", 704'(rsp_mac), 704'd0);
    check_eq("mid_rst_rsp_err", 704'(rsp_err), 704'd0);
    check_eq("mid_rst_key_valid", 704'(key_valid), 704'd0);
    check_eq("mid_rst_start_hmac", 704'(start_hmac), 704'd0);
    check_eq("mid_rst_puf_input", puf_input, 704'd0);
    check_eq("mid_rst_msg_valid", 704'(msg_valid), 704'd0);
    check_eq("mid_rst_msg_word", 704'(msg_word), 704'd0);
    reset = 1'b1;
    req_wvalid = '0;
    req_valid = '0;
    ref_ptr = 0;
    @(negedge clk);
    key_exp = puf_seed[511:0];
    p0 = puf_cnt;
    req_valid = 4'b0100;
    serve(5, 1'b0, 1'b0, gi);
    check_eq("post_rst_puf", 704'(puf_cnt - p0), 704'd1);
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
